game_render_sequencer: RTL and testbench
========================================

# game_render_sequencer

Parametrised frame renderer for the plotting path into the VGA adapter. On each `start` it clears the screen to a background colour, then scans an object table of `NUM_OBJ` slots. Each valid object is drawn as a `SPR_W`×`SPR_H` sprite from an external sprite ROM of `NUM_TYPES` types. It feeds one pixel per cycle through a 2-stage pipeline, with a back-pressure stall and off-screen clipping.

## Interface
Parameters:
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `XW` / `YW`, 8 / 7: coordinate widths.
- `SPR_W` / `SPR_H`, 16 / 16: sprite size. Powers of two.
- `NUM_TYPES`, 4: sprite types (gold, stone, ...).
- `TW`, 2: type index width.
- `NUM_OBJ`, 12: object table slots.
- `OW`, 4: slot index width.
- `COLW`, 3: colour width.
- `KEY_COLOR`, 3'd0: transparency key.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a frame from IDLE.
- `bg_color` in COLW: clear colour, sampled continuously during CLEAR.
- `obj_idx` out OW: slot being read.
- `obj_valid` in 1: slot occupied. Table reads are combinational, in the same cycle as `obj_idx`.
- `obj_type` in TW: sprite type of the slot.
- `obj_x` in XW: object top-left x.
- `obj_y` in YW: object top-left y.
- `spr_type` out TW: sprite ROM type select.
- `spr_addr` out log2(SPR_W*SPR_H): sprite ROM address, row*SPR_W+col.
- `spr_color` in COLW: ROM data, valid one cycle after `spr_type`/`spr_addr`.
- `stall` in 1: downstream not ready.
- `plot_x` out XW: pixel x.
- `plot_y` out YW: pixel y.
- `plot_color` out COLW: pixel colour.
- `writeEn` out 1: write the pixel this cycle.
- `busy` out 1: high from `start` acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse at frame end.

## Operation
- **IDLE**
  - `start` → CLEAR.
  - Pixel counters are zeroed.
- **CLEAR**
  - Stage 0 raster-scans x=0..SCREEN_W-1 (inner loop), then y=0..SCREEN_H-1.
  - Each issued pixel carries colour `bg_color`.
  - After (SCREEN_W-1, SCREEN_H-1) is issued → FETCH with slot=0.
- **FETCH**
  - Drive `obj_idx`=slot.
  - If `obj_valid`: latch `obj_type`, `obj_x` and `obj_y`, then → DRAW.
  - If not `obj_valid`: → NEXT.
  - FETCH takes 1 cycle and issues no pixel.
- **DRAW**
  - Stage 0 issues col=0..SPR_W-1 (inner loop), then row=0..SPR_H-1.
  - Each pixel drives `spr_addr`=row*SPR_W+col and the latched type.
  - Pixel coordinate is x=obj_x+col, y=obj_y+row, computed at XW+1 / YW+1 bits.
  - After the last pixel is issued → NEXT.
- **NEXT**
  - If slot==NUM_OBJ-1 → DRAIN.
  - Otherwise slot+1 → FETCH.
- **DRAIN**
  - Wait until the stage-1 valid bit is clear.
  - Then → DONE.
- **DONE**
  - `frame_done`=1 for one cycle → IDLE.
- **Pipeline**
  - Stage 0 is the counter/address stage. Stage 1 registers `plot_x`, `plot_y` and a valid bit.
  - Stage-1 colour is `spr_color` for sprite pixels and the registered `bg_color` for clear pixels.
  - Stage 0 of the next object may overlap stage 1 of the previous object.
- **Clipping:** pixels with x≥SCREEN_W or y≥SCREEN_H pass through the pipeline with `writeEn`=0. They still consume their cycle.
- `writeEn` = s1_valid & ~stall & in_bounds, further gated by transparency when configured (see Configuration).
- Later objects overwrite earlier objects: slot order is draw order.
- `start` while `busy` is ignored.
- `obj_*` inputs are sampled only in FETCH.

## Timing
- **Reset:** asynchronous. Every output goes to 0 and the FSM goes to IDLE. A reset mid-frame aborts the frame immediately, with no `frame_done`.
- **Start latency:** `start` at cycle 0; first clear pixel has `writeEn`=1 at cycle 2 (CLEAR entered at cycle 1, stage 1 at cycle 2).
- **Unstalled frame length** = 1 (start) + SCREEN_W*SCREEN_H + NUM_OBJ (FETCH) + NUM_OBJ (NEXT) + Σ_valid SPR_W*SPR_H + drain(1) + 1 (DONE).
- **`stall`:** freezes the FSM, the counters and stage 1. `plot_*` are held and `writeEn` is 0. The held pixel is written in the first cycle `stall` is low. The ROM address is held, so `spr_color` stays valid.
- `stall` has no effect in IDLE.
- **Wrap:** counters wrap to 0 only at state exit. No pixel is issued twice or skipped.

## Configuration
- **`RENDER_TRANSPARENT_EN` defined:** a sprite pixel with `spr_color`==KEY_COLOR gets `writeEn`=0, while still consuming its cycle. Clear pixels are never keyed.
- **`RENDER_TRANSPARENT_EN` undefined:** all in-bounds sprite pixels are written, including key-coloured ones. Timing is identical with and without the macro.

## Test plan
Parameters for all scenarios: SCREEN 8×4, SPR 2×2, NUM_OBJ 2.
- **Clear only:** no valid slots, `bg_color`=5, `start`.
  - 32 writes of colour 5, in raster order (0,0)…(7,3).
  - Then `frame_done` on frame cycle 32+2+2+1+1 = 38, and `busy` low afterwards.
- **Sprite draw:** slot1 valid, type 2 at (3,1), ROM returns addr+1.
  - After the clear, writes (3,1)=1, (4,1)=2, (3,2)=3, (4,2)=4.
  - ROM sees `spr_type`=2.
- **Clipping:** object at (7,3).
  - Only (7,3) is written. The other 3 pixels have `writeEn`=0.
  - Frame length is the same as an unclipped object.
- **Stall:** `stall` high for 3 cycles during DRAW.
  - `plot_*` are held, with no writes.
  - The held pixel is written once after release, and the total write count is unchanged.
- **Transparency:** with `RENDER_TRANSPARENT_EN`, ROM returns 0 at addr 1.
  - (4,1) is not written.
  - Without the macro, (4,1) is written with colour 0.
- **Reset and ignored start:**
  - Assert `resetn`=0 mid-CLEAR: outputs go to 0 immediately, with no `frame_done`.
  - A `start` during `busy` has no effect.

Source files
------------

// File: rtl/game_render_sequencer_if.sv
// Bus bundle for game_render_sequencer: frame control, object-table read,
// sprite-ROM read and the plotting port toward the VGA adapter.
// "master" is the host/environment side, "slave" is the sequencer.
interface game_render_sequencer_if #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int TW   = 2,
    parameter int OW   = 4,
    parameter int COLW = 3,
    parameter int AW   = 8
);
    logic            start;
    logic [COLW-1:0] bg_color;
    logic [OW-1:0]   obj_idx;
    logic            obj_valid;
    logic [TW-1:0]   obj_type;
    logic [XW-1:0]   obj_x;
    logic [YW-1:0]   obj_y;
    logic [TW-1:0]   spr_type;
    logic [AW-1:0]   spr_addr;
    logic [COLW-1:0] spr_color;
    logic            stall;
    logic [XW-1:0]   plot_x;
    logic [YW-1:0]   plot_y;
    logic [COLW-1:0] plot_color;
    logic            writeEn;
    logic            busy;
    logic            frame_done;

    modport master (
        output start, bg_color, obj_valid, obj_type, obj_x, obj_y, spr_color, stall,
        input  obj_idx, spr_type, spr_addr, plot_x, plot_y, plot_color, writeEn,
               busy, frame_done
    );

    modport slave (
        input  start, bg_color, obj_valid, obj_type, obj_x, obj_y, spr_color, stall,
        output obj_idx, spr_type, spr_addr, plot_x, plot_y, plot_color, writeEn,
               busy, frame_done
    );
endinterface

// File: rtl/game_render_sequencer.sv
// Frame renderer: clears the screen to bg_color, then draws every valid
// object-table slot as an SPR_W x SPR_H sprite (powers of two, >= 2) read
// from an external ROM. One pixel per cycle through a 2-stage pipeline with
// back-pressure stall and off-screen clipping.
// Optional feature macro: RENDER_TRANSPARENT_EN (sprite pixels equal to
// KEY_COLOR are not written; timing unchanged).
module game_render_sequencer #(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int NUM_TYPES = 4,
    parameter int TW        = 2,
    parameter int NUM_OBJ   = 12,
    parameter int OW        = 4,
    parameter int COLW      = 3,
    parameter logic [COLW-1:0] KEY_COLOR = '0
) (
    input logic clk,
    input logic resetn,
    game_render_sequencer_if.slave bus
);
    localparam int CB = $clog2(SPR_W);
    localparam int RB = $clog2(SPR_H);
    localparam int AW = CB + RB;

    localparam logic [XW-1:0] CLR_X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] CLR_Y_LAST = YW'(SCREEN_H - 1);
    localparam logic [XW-1:0] SPR_X_LAST = XW'(SPR_W - 1);
    localparam logic [YW-1:0] SPR_Y_LAST = YW'(SPR_H - 1);
    localparam logic [OW-1:0] SLOT_LAST  = OW'(NUM_OBJ - 1);

    if (NUM_TYPES > (1 << TW)) begin : g_type_width_check
        $error("TW too narrow for NUM_TYPES");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_DRAW, S_NEXT, S_DRAIN, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [XW-1:0]   cnt_x, cnt_x_n;
    logic [YW-1:0]   cnt_y, cnt_y_n;
    logic [OW-1:0]   slot, slot_n;
    logic            load_obj;
    logic            adv;
    logic [TW-1:0]   lat_type;
    logic [XW-1:0]   lat_x;
    logic [YW-1:0]   lat_y;

    logic            s0_issue;
    logic [XW:0]     s0_x;
    logic [YW:0]     s0_y;
    logic [AW-1:0]   s0_addr;
    logic            s0_inb;

    logic            s1_valid;
    logic [XW-1:0]   s1_x;
    logic [YW-1:0]   s1_y;
    logic            s1_inb;
    logic            s1_spr;
    logic [COLW-1:0] s1_bg;
    logic [AW-1:0]   s1_addr;
    logic            s1_keyed;

    // Stall freezes everything except the idle wait and the done pulse.
    assign adv = ~bus.stall || (state == S_IDLE) || (state == S_DONE);

    // Next-state, counter and slot sequencing.
    always_comb begin
        state_n  = state;
        cnt_x_n  = cnt_x;
        cnt_y_n  = cnt_y;
        slot_n   = slot;
        load_obj = 1'b0;
        if (adv) begin
            case (state)
                S_IDLE: begin
                    cnt_x_n = '0;
                    cnt_y_n = '0;
                    slot_n  = '0;
                    if (bus.start) state_n = S_CLEAR;
                end
                S_CLEAR: begin
                    if (cnt_x == CLR_X_LAST) begin
                        cnt_x_n = '0;
                        if (cnt_y == CLR_Y_LAST) begin
                            cnt_y_n = '0;
                            slot_n  = '0;
                            state_n = S_FETCH;
                        end else begin
                            cnt_y_n = cnt_y + 1'b1;
                        end
                    end else begin
                        cnt_x_n = cnt_x + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.obj_valid) begin
                        load_obj = 1'b1;
                        state_n  = S_DRAW;
                    end else begin
                        state_n = S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (cnt_x == SPR_X_LAST) begin
                        cnt_x_n = '0;
                        if (cnt_y == SPR_Y_LAST) begin
                            cnt_y_n = '0;
                            state_n = S_NEXT;
                        end else begin
                            cnt_y_n = cnt_y + 1'b1;
                        end
                    end else begin
                        cnt_x_n = cnt_x + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (slot == SLOT_LAST) begin
                        state_n = S_DRAIN;
                    end else begin
                        slot_n  = slot + 1'b1;
                        state_n = S_FETCH;
                    end
                end
                S_DRAIN: if (!s1_valid) state_n = S_DONE;
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Control registers: FSM state, raster counters, slot and latched object.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt_x    <= '0;
            cnt_y    <= '0;
            slot     <= '0;
            lat_type <= '0;
            lat_x    <= '0;
            lat_y    <= '0;
        end else begin
            state <= state_n;
            cnt_x <= cnt_x_n;
            cnt_y <= cnt_y_n;
            slot  <= slot_n;
            if (load_obj) begin
                lat_type <= bus.obj_type;
                lat_x    <= bus.obj_x;
                lat_y    <= bus.obj_y;
            end
        end
    end

    // Stage 0: pixel coordinate, ROM address and clip test for the issued pixel.
    always_comb begin
        s0_issue = (state == S_CLEAR) || (state == S_DRAW);
        if (state == S_DRAW) begin
            s0_x    = {1'b0, lat_x} + {1'b0, cnt_x};
            s0_y    = {1'b0, lat_y} + {1'b0, cnt_y};
            s0_addr = {cnt_y[RB-1:0], cnt_x[CB-1:0]};
        end else begin
            s0_x    = {1'b0, cnt_x};
            s0_y    = {1'b0, cnt_y};
            s0_addr = '0;
        end
        s0_inb = (s0_x < (XW+1)'(SCREEN_W)) && (s0_y < (YW+1)'(SCREEN_H));
    end

    // Stage 1: registered pixel, held while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_inb   <= 1'b0;
            s1_spr   <= 1'b0;
            s1_bg    <= '0;
            s1_addr  <= '0;
        end else if (adv) begin
            s1_valid <= s0_issue;
            if (s0_issue) begin
                s1_x    <= s0_x[XW-1:0];
                s1_y    <= s0_y[YW-1:0];
                s1_inb  <= s0_inb;
                s1_spr  <= (state == S_DRAW);
                s1_bg   <= bus.bg_color;
                s1_addr <= s0_addr;
            end
        end
    end

`ifdef RENDER_TRANSPARENT_EN
    assign s1_keyed = s1_spr && (bus.spr_color == KEY_COLOR);
`else
    assign s1_keyed = 1'b0;
`endif

    assign bus.obj_idx    = slot;
    assign bus.spr_type   = lat_type;
    // Stage 0 already points at the next pixel while stalled, so the ROM is
    // re-addressed with the held stage-1 pixel to keep spr_color matching it.
    assign bus.spr_addr   = bus.stall ? s1_addr : s0_addr;
    assign bus.plot_x     = s1_x;
    assign bus.plot_y     = s1_y;
    assign bus.plot_color = s1_spr ? bus.spr_color : s1_bg;
    assign bus.writeEn    = s1_valid && !bus.stall && s1_inb && !s1_keyed;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = (state == S_DONE);
endmodule

// File: tb/tb_game_render_sequencer.sv
// Scoreboard bench for game_render_sequencer on an 8x4 screen with 2x2
// sprites and two object slots. Expected writes are queued per frame and
// checked by an independent monitor on the falling clock edge.
module tb_game_render_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    game_render_sequencer_if #(
        .XW(3), .YW(2), .TW(2), .OW(1), .COLW(3), .AW(2)
    ) bus ();

    game_render_sequencer #(
        .SCREEN_W(8), .SCREEN_H(4), .XW(3), .YW(2), .SPR_W(2), .SPR_H(2),
        .NUM_TYPES(4), .TW(2), .NUM_OBJ(2), .OW(1), .COLW(3), .KEY_COLOR(3'd0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t q[$];
    int n_checks = 0;
    int n_fail = 0;
    int frame_writes = 0;

    // object table and sprite ROM models
    logic       tv[2];
    logic [1:0] tt[2];
    logic [2:0] tx[2];
    logic [1:0] ty[2];
    logic [1:0] rom_type = 2'd2;
    logic       rom_zero_addr1 = 1'b0;

    assign bus.obj_valid = tv[bus.obj_idx];
    assign bus.obj_type  = tt[bus.obj_idx];
    assign bus.obj_x     = tx[bus.obj_idx];
    assign bus.obj_y     = ty[bus.obj_idx];

    function automatic logic [2:0] rom_color(input logic [1:0] t, input logic [1:0] a);
        if (t != rom_type) return 3'd7;
        if (rom_zero_addr1 && a == 2'd1) return 3'd0;
        return 3'(a) + 3'd1;
    endfunction

    always_ff @(posedge clk) bus.spr_color <= rom_color(bus.spr_type, bus.spr_addr);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn && bus.writeEn) begin
            frame_writes++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%0d expected no write",
                         bus.plot_x, bus.plot_y, bus.plot_color);
            end else begin
                pix_t e;
                e = q.pop_front();
                if (int'(bus.plot_x) != e.x || int'(bus.plot_y) != e.y ||
                    int'(bus.plot_color) != e.c) begin
                    n_fail++;
                    $display("FAIL pixel_write: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                             bus.plot_x, bus.plot_y, bus.plot_color, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic push(input int x, input int y, input int c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        q.push_back(p);
    endtask

    task automatic push_clear(input int c);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                push(x, y, c);
    endtask

    task automatic set_obj(input int s, input logic v, input int t, input int x, input int y);
        tv[s] = v;
        tt[s] = 2'(t);
        tx[s] = 3'(x);
        ty[s] = 2'(y);
    endtask

    // Start a frame at cycle 0 and follow it cycle by cycle until frame_done.
    task automatic run_frame(input int exp_done, input int exp_writes, input int stall_lo,
                             input int stall_hi, input int hold_x, input int hold_y,
                             input int ign_at);
        int  k;
        bit  seen;
        frame_writes = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        k = 1;
        seen = 1'b0;
        while (!seen && k < 200) begin
            bus.stall = (k >= stall_lo) && (k <= stall_hi);
            bus.start = (k == ign_at);
            #1;
            if (k == 1) check("busy_after_start", int'(bus.busy), 1);
            if (k == 2 && stall_lo != 2)
                check("first_write_latency", int'({bus.writeEn, bus.plot_x, bus.plot_y}), 32);
            if (bus.stall) begin
                check("stall_hold_x", int'(bus.plot_x), hold_x);
                check("stall_hold_y", int'(bus.plot_y), hold_y);
                check("stall_no_write", int'(bus.writeEn), 0);
            end
            if (bus.frame_done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("frame_done_cycle", seen ? k : -1, exp_done);
        bus.stall = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("done_pulse_busy_low", int'({bus.frame_done, bus.busy}), 0);
        check("frame_write_count", frame_writes, exp_writes);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        bit bad;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.bg_color = 3'd0;
        set_obj(0, 1'b0, 0, 0, 0);
        set_obj(1, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({bus.plot_x, bus.plot_y, bus.plot_color, bus.writeEn,
                                     bus.busy, bus.frame_done, bus.obj_idx, bus.spr_type,
                                     bus.spr_addr}), 0);
        resetn = 1'b1;

        // clear only
        bus.bg_color = 3'd5;
        push_clear(5);
        run_frame(38, 32, 0, -1, 0, 0, -1);

        // single sprite in slot 1
        bus.bg_color = 3'd1;
        set_obj(1, 1'b1, 2, 3, 1);
        push_clear(1);
        push(3, 1, 1); push(4, 1, 2); push(3, 2, 3); push(4, 2, 4);
        run_frame(42, 36, 0, -1, 0, 0, -1);

        // clipping at the bottom-right corner
        bus.bg_color = 3'd6;
        set_obj(1, 1'b1, 2, 7, 3);
        push_clear(6);
        push(7, 3, 1);
        run_frame(42, 33, 0, -1, 0, 0, -1);

        // stall for three cycles while the first sprite pixel sits in stage 1
        bus.bg_color = 3'd1;
        set_obj(1, 1'b1, 2, 3, 1);
        push_clear(1);
        push(3, 1, 1); push(4, 1, 2); push(3, 2, 3); push(4, 2, 4);
        run_frame(45, 36, 37, 39, 3, 1, -1);

        // key colour at sprite address 1
        bus.bg_color = 3'd2;
        rom_zero_addr1 = 1'b1;
        push_clear(2);
        push(3, 1, 1);
`ifdef RENDER_TRANSPARENT_EN
        push(3, 2, 3); push(4, 2, 4);
        run_frame(42, 35, 0, -1, 0, 0, -1);
`else
        push(4, 1, 0); push(3, 2, 3); push(4, 2, 4);
        run_frame(42, 36, 0, -1, 0, 0, -1);
`endif
        rom_zero_addr1 = 1'b0;

        // start pulse while busy is ignored
        set_obj(1, 1'b0, 0, 0, 0);
        bus.bg_color = 3'd4;
        push_clear(4);
        run_frame(38, 32, 0, -1, 0, 0, 10);

        // reset mid-clear: pixels 0..7 are written on cycles 2..9, then abort
        bus.bg_color = 3'd3;
        for (int x = 0; x < 8; x++) push(x, 0, 3);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("reset_mid_clear", int'({bus.plot_x, bus.plot_y, bus.plot_color, bus.writeEn,
                                       bus.busy, bus.frame_done, bus.obj_idx, bus.spr_type,
                                       bus.spr_addr}), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        bad = 1'b0;
        repeat (45) begin
            @(posedge clk); #1;
            if (bus.frame_done || bus.busy) bad = 1'b1;
        end
        check("no_done_after_abort", int'(bad), 0);
        check("abort_queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
